bios_upload_loader: RTL and testbench
=====================================

Name: bios_upload_loader

Overview:
- Upstream feeder of the BIOS ROM upload port.
- Converts the MiSTer OSD byte-wide ioctl download stream into 16-bit word writes on the BIOS `upload_*` interface.
- Pairs even/odd bytes, flushes unpaired bytes with a partial byte-select, and drops writes beyond the ROM depth.
- Holds the CPU in reset while a BIOS image is loading and for a short settle period afterwards.

Parameters:
- DEPTH, 8192, BIOS ROM depth in 16-bit words; byte offsets at or above 2*DEPTH are dropped.
- BIOS_INDEX, 8'h00, ioctl_index value identifying a BIOS download; any other index is ignored.
- HOLD_CYCLES, 16, clk cycles `cpu_hold` stays asserted after the last write (1..65535).

Ports:
- clk  in  1  system clock; sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  high for the duration of any OSD download.
- ioctl_index  in  8  download target selector.
- ioctl_wr  in  1  one-cycle strobe: ioctl_addr/ioctl_dout valid.
- ioctl_addr  in  25  byte offset within the image.
- ioctl_dout  in  8  byte data.
- upload_wr_req  out  1  one-cycle BIOS write strobe.
- upload_addr  out  13  word address, bits [13:1].
- upload_data  out  16  write data; low byte = even byte.
- upload_bytesel  out  2  byte enables; [0] = low byte.
- cpu_hold  out  1  keep CPU in reset.
- load_done  out  1  sticky: a BIOS download has completed since reset.
- overflow  out  1  sticky per download: at least one byte was dropped as out of range.
- word_count  out  14  number of upload_wr_req pulses issued in the current/last download.
- checksum  out  16  see Optional Feature.

Behaviour:
- Reset (async, reset_n low):
  - All outputs are 0; state is IDLE; the pending byte is discarded.
  - Deasserting reset mid-download does not resume the load: the state stays IDLE until ioctl_download is seen low.
- "active" means ioctl_download & (ioctl_index == BIOS_INDEX).
- State machine:
  - IDLE -> LOAD on a rising edge of active. On this edge: clear word_count, overflow and checksum; set cpu_hold = 1.
  - LOAD: handle strobes as below. active falling -> FLUSH.
  - FLUSH: if a byte is pending, issue a write with bytesel 2'b01 in this cycle. Reload the hold counter to HOLD_CYCLES. Go to HOLD next cycle.
  - HOLD: decrement the counter each cycle; at 0, go to IDLE, cpu_hold = 0, load_done = 1.
  - A new rising edge of active during HOLD goes directly to LOAD (the counter is abandoned; cpu_hold stays 1).
- Strobe handling in LOAD, on ioctl_wr:
  - Range check: if ioctl_addr >= 2*DEPTH, drop the byte and set overflow.
  - Even address: latch the low byte and word address into the pending register. If a byte was already pending, issue that pending byte as a bytesel-2'b01 write in the same cycle.
  - Odd address matching the pending word address: issue a full write (bytesel 2'b11, data = {dout, pending}) and clear pending.
  - Odd address with no pending byte, or a mismatched pending byte:
    - Issue {dout, 8'h00} with bytesel 2'b10.
    - The mismatched pending byte is flushed in the following cycle with bytesel 2'b01. The ioctl protocol guarantees ≥2 idle cycles between strobes, so the flush never collides with a new strobe.
- Output timing:
  - All write outputs are registered. upload_wr_req is high for exactly 1 cycle, the cycle after the triggering ioctl_wr.
  - Address, data and bytesel are valid in the same cycle as upload_wr_req. They hold their last value otherwise; only upload_wr_req qualifies them.
  - word_count increments per pulse and saturates at 2^14-1.
- ioctl_wr while not in LOAD is ignored.

Optional Feature:
- Macro BIOS_LOADER_CHECKSUM_EN.
- Defined:
  - checksum accumulates a 16-bit wrapping sum of every issued write's upload_data, with disabled bytes counted as 0.
  - It is cleared on entry to LOAD and is stable once load_done rises.
- Undefined: checksum is tied to 16'h0000 and no accumulator logic is built.

Test Plan:
- Reset asserted mid-LOAD with 1 byte pending -> all outputs 0. After release with ioctl_download still high: no writes and cpu_hold = 0 until a fresh download starts.
- Download of index 0 with bytes 0x34@0, 0x12@1, 0x78@2, 0x56@3 -> two pulses: addr 0 data 16'h1234 bsel 11, then addr 1 data 16'h5678 bsel 11. word_count = 2. checksum = 16'h68AC if enabled.
- Odd-length image of 3 bytes (AA, BB, CC) then download drops -> final FLUSH write at addr 1, data 16'h00CC, bsel 01. cpu_hold stays 1 for HOLD_CYCLES = 16 cycles after FLUSH, then load_done = 1.
- Download with index 8'h01 -> no upload_wr_req, cpu_hold stays 0, load_done unchanged.
- Byte at offset 2*DEPTH (16384) -> dropped, overflow = 1, no write. Preceding in-range words are still written.
- Odd byte 0x99 at offset 5 with no even predecessor -> write addr 2, data 16'h9900, bsel 10.

Source files
------------

// File: rtl/bios_upload_loader.sv
// Converts the byte-wide OSD ioctl download stream into 16-bit BIOS ROM upload writes.
// Define BIOS_LOADER_CHECKSUM_EN to build the running checksum of issued write data.
module bios_upload_loader #(
  parameter int          DEPTH       = 8192,
  parameter logic [7:0]  BIOS_INDEX  = 8'h00,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        upload_wr_req,
  output logic [12:0] upload_addr,
  output logic [15:0] upload_data,
  output logic [1:0]  upload_bytesel,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        overflow,
  output logic [13:0] word_count,
  output logic [15:0] checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, HOLD} state_t;

  localparam logic [24:0] ADDR_LIMIT = 25'(2 * DEPTH);
  localparam logic [15:0] HOLD_INIT  = 16'(HOLD_CYCLES);
  localparam logic [13:0] COUNT_MAX  = '1;

  state_t      state;
  logic        active, active_q, armed, rise;
  logic        pend_vld, flush_pend;
  logic [12:0] pend_addr;
  logic [7:0]  pend_byte;
  logic [15:0] hold_cnt;
  logic [12:0] strobe_addr;
  logic        in_range, load_wr;

  logic        wr_go;
  logic [12:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_bsel;

  assign active      = ioctl_download && (ioctl_index == BIOS_INDEX);
  // armed blocks a load from resuming when reset is released mid-download
  assign rise        = active && !active_q && armed;
  assign strobe_addr = ioctl_addr[13:1];
  assign in_range    = ioctl_addr < ADDR_LIMIT;
  assign load_wr     = (state == LOAD) && ioctl_wr;

  always_comb begin
    wr_go   = 1'b0;
    wr_addr = pend_addr;
    wr_data = {8'h00, pend_byte};
    wr_bsel = 2'b01;
    case (state)
      LOAD: begin
        if (load_wr && in_range) begin
          if (!ioctl_addr[0]) begin
            wr_go = pend_vld;
          end else if (pend_vld && (pend_addr == strobe_addr)) begin
            wr_go   = 1'b1;
            wr_addr = strobe_addr;
            wr_data = {ioctl_dout, pend_byte};
            wr_bsel = 2'b11;
          end else begin
            wr_go   = 1'b1;
            wr_addr = strobe_addr;
            wr_data = {ioctl_dout, 8'h00};
            wr_bsel = 2'b10;
          end
        end else if (flush_pend) begin
          wr_go = 1'b1;
        end
      end
      FLUSH:   wr_go = pend_vld;
      default: wr_go = 1'b0;
    endcase
  end

`ifdef BIOS_LOADER_CHECKSUM_EN
  logic [15:0] csum;
  assign checksum = csum;
`else
  assign checksum = 16'h0000;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      active_q       <= 1'b0;
      armed          <= 1'b0;
      pend_vld       <= 1'b0;
      flush_pend     <= 1'b0;
      pend_addr      <= '0;
      pend_byte      <= '0;
      hold_cnt       <= '0;
      upload_wr_req  <= 1'b0;
      upload_addr    <= '0;
      upload_data    <= '0;
      upload_bytesel <= '0;
      cpu_hold       <= 1'b0;
      load_done      <= 1'b0;
      overflow       <= 1'b0;
      word_count     <= '0;
`ifdef BIOS_LOADER_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      active_q      <= active;
      upload_wr_req <= wr_go;
      if (!ioctl_download) armed <= 1'b1;
      if (wr_go) begin
        upload_addr    <= wr_addr;
        upload_data    <= wr_data;
        upload_bytesel <= wr_bsel;
        if (word_count != COUNT_MAX) word_count <= word_count + 14'd1;
`ifdef BIOS_LOADER_CHECKSUM_EN
        csum <= csum + wr_data;
`endif
      end
      case (state)
        LOAD: begin
          if (load_wr) begin
            if (!in_range) begin
              overflow <= 1'b1;
            end else if (!ioctl_addr[0]) begin
              pend_vld  <= 1'b1;
              pend_addr <= strobe_addr;
              pend_byte <= ioctl_dout;
            end else if (pend_vld && (pend_addr == strobe_addr)) begin
              pend_vld <= 1'b0;
            end else if (pend_vld) begin
              flush_pend <= 1'b1;
            end
          end else if (flush_pend) begin
            flush_pend <= 1'b0;
            pend_vld   <= 1'b0;
          end
          if (!active) state <= FLUSH;
        end
        FLUSH: begin
          pend_vld   <= 1'b0;
          flush_pend <= 1'b0;
          hold_cnt   <= HOLD_INIT;
          state      <= HOLD;
        end
        default: begin
          if (rise) begin
            state      <= LOAD;
            cpu_hold   <= 1'b1;
            word_count <= '0;
            overflow   <= 1'b0;
            pend_vld   <= 1'b0;
            flush_pend <= 1'b0;
`ifdef BIOS_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end else if (state == HOLD) begin
            if (hold_cnt == 16'd0) begin
              state     <= IDLE;
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - 16'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bios_upload_loader.sv
// Randomized self-checking bench for bios_upload_loader against a queue-based write model.
module tb_bios_upload_loader;

  localparam int         DEPTH = 8192;
  localparam int         HOLD  = 16;
  localparam logic [7:0] BIDX  = 8'h00;

  logic        clk, reset_n;
  logic        ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        upload_wr_req, cpu_hold, load_done, overflow;
  logic [12:0] upload_addr;
  logic [15:0] upload_data, checksum;
  logic [1:0]  upload_bytesel;
  logic [13:0] word_count;

  bios_upload_loader #(.DEPTH(DEPTH), .BIOS_INDEX(BIDX), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .upload_wr_req(upload_wr_req), .upload_addr(upload_addr), .upload_data(upload_data),
    .upload_bytesel(upload_bytesel), .cpu_hold(cpu_hold), .load_done(load_done),
    .overflow(overflow), .word_count(word_count), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] a;
    logic [15:0] d;
    logic [1:0]  b;
  } wr_t;

  wr_t act_q[$];
  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  bit          m_pv;
  logic [12:0] m_pa;
  logic [7:0]  m_pb;
  bit          m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (reset_n && upload_wr_req) act_q.push_back(wr_t'({upload_addr, upload_data, upload_bytesel}));

  function automatic void push_exp(input logic [12:0] a, input logic [15:0] d, input logic [1:0] b);
    exp_q.push_back(wr_t'({a, d, b}));
  endfunction

  // Byte pairing as seen from the image: low byte even, high byte odd, loners flushed alone.
  function automatic void model_strobe(input int addr, input logic [7:0] d);
    logic [12:0] wa;
    if (addr >= 2 * DEPTH) begin
      m_ovf = 1'b1;
      return;
    end
    wa = 13'(addr / 2);
    if (addr % 2 == 0) begin
      if (m_pv) push_exp(m_pa, {8'h00, m_pb}, 2'b01);
      m_pv = 1'b1; m_pa = wa; m_pb = d;
    end else if (m_pv && m_pa == wa) begin
      push_exp(wa, {d, m_pb}, 2'b11);
      m_pv = 1'b0;
    end else begin
      push_exp(wa, {d, 8'h00}, 2'b10);
      if (m_pv) push_exp(m_pa, {8'h00, m_pb}, 2'b01);
      m_pv = 1'b0;
    end
  endfunction

  function automatic void model_end();
    if (m_pv) push_exp(m_pa, {8'h00, m_pb}, 2'b01);
    m_pv = 1'b0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    m_pv = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
    act_q.delete();
    idle(2);
  endtask

  task automatic strobe(input int addr, input logic [7:0] d);
    @(negedge clk);
    ioctl_addr = 25'(addr);
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    idle(3);
    if (ioctl_index == BIDX) model_strobe(addr, d);
  endtask

  task automatic end_dl();
    int n;
    @(negedge clk);
    ioctl_download = 1'b0;
    if (ioctl_index == BIDX) model_end();
    n = 0;
    while (cpu_hold !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("hold_release_timeout", 32'(cpu_hold), 32'd0);
    idle(2);
  endtask

  task automatic compare_writes(input string tag);
    logic [15:0] sum;
    int          n;
    sum = 16'h0;
    chk({tag, "_nwr"}, 32'(act_q.size()), 32'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_wr"}, 32'(act_q[i]), 32'(exp_q[i]));
    foreach (exp_q[i]) sum = sum + exp_q[i].d;
    chk({tag, "_wcnt"}, 32'(word_count), (exp_q.size() > 16383) ? 32'd16383 : 32'(exp_q.size()));
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
`ifdef BIOS_LOADER_CHECKSUM_EN
    chk({tag, "_csum"}, 32'(checksum), 32'(sum));
`else
    chk({tag, "_csum"}, 32'(checksum), 32'd0);
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_req"}, 32'(upload_wr_req), 32'd0);
    chk({tag, "_addr"}, 32'(upload_addr), 32'd0);
    chk({tag, "_data"}, 32'(upload_data), 32'd0);
    chk({tag, "_bsel"}, 32'(upload_bytesel), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_wcnt"}, 32'(word_count), 32'd0);
    chk({tag, "_csum"}, 32'(checksum), 32'd0);
  endtask

  initial begin
    int t_flush, t_rel, cur, a;
    logic ld_before;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'h00;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    idle(3);
    check_zero("reset");
    reset_n = 1'b1;
    idle(3);

    // Two full words
    start_dl(BIDX);
    chk("t2_hold_on", 32'(cpu_hold), 32'd1);
    strobe(0, 8'h34); strobe(1, 8'h12); strobe(2, 8'h78); strobe(3, 8'h56);
    end_dl();
    compare_writes("t2");
    if (act_q.size() == 2) begin
      chk("t2_w0", 32'(act_q[0]), 32'({13'd0, 16'h1234, 2'b11}));
      chk("t2_w1", 32'(act_q[1]), 32'({13'd1, 16'h5678, 2'b11}));
    end else chk("t2_wr_count", 32'(act_q.size()), 32'd2);
`ifdef BIOS_LOADER_CHECKSUM_EN
    chk("t2_csum_const", 32'(checksum), 32'h68AC);
`endif
    chk("t2_done", 32'(load_done), 32'd1);

    // Odd-length image, flush and hold duration
    start_dl(BIDX);
    strobe(0, 8'hAA); strobe(1, 8'hBB); strobe(2, 8'hCC);
    @(negedge clk);
    ioctl_download = 1'b0;
    model_end();
    t_flush = -1; t_rel = -1;
    for (int n = 0; n < 100 && t_rel < 0; n++) begin
      @(negedge clk);
      if (upload_wr_req && upload_bytesel == 2'b01 && t_flush < 0) t_flush = n;
      if (!cpu_hold && t_rel < 0) t_rel = n;
    end
    chk("t3_flush_seen", 32'(t_flush >= 0), 32'd1);
    chk("t3_hold_len_ok", 32'((t_rel - t_flush >= HOLD) && (t_rel - t_flush <= HOLD + 1)), 32'd1);
    chk("t3_done", 32'(load_done), 32'd1);
    idle(2);
    compare_writes("t3");
    if (act_q.size() == 2) chk("t3_flush_wr", 32'(act_q[1]), 32'({13'd1, 16'h00CC, 2'b01}));

    // Foreign index is ignored
    ld_before = load_done;
    start_dl(8'h01);
    strobe(0, 8'h11); strobe(1, 8'h22);
    chk("t4_hold_off", 32'(cpu_hold), 32'd0);
    end_dl();
    chk("t4_nwr", 32'(act_q.size()), 32'd0);
    chk("t4_done", 32'(load_done), 32'(ld_before));

    // Out-of-range byte
    start_dl(BIDX);
    strobe(0, 8'h11); strobe(1, 8'h22); strobe(2 * DEPTH, 8'h33);
    chk("t5_ovf_live", 32'(overflow), 32'd1);
    end_dl();
    compare_writes("t5");
    if (act_q.size() == 1) chk("t5_w0", 32'(act_q[0]), 32'({13'd0, 16'h2211, 2'b11}));

    // Lone odd byte
    start_dl(BIDX);
    strobe(5, 8'h99);
    end_dl();
    compare_writes("t6");
    if (act_q.size() == 1) chk("t6_w0", 32'(act_q[0]), 32'({13'd2, 16'h9900, 2'b10}));

    // Randomized downloads
    for (int r = 0; r < 10; r++) begin
      start_dl(BIDX);
      cur = int'($urandom_range(0, 2 * DEPTH - 1));
      for (int k = 0; k < int'($urandom_range(1, 14)); k++) begin
        case ($urandom_range(0, 3))
          0, 1: begin a = cur; cur++; end
          2: a = int'($urandom_range(0, 2 * DEPTH - 1));
          default: a = int'($urandom_range(2 * DEPTH - 6, 2 * DEPTH + 6));
        endcase
        strobe(a, 8'($urandom()));
      end
      end_dl();
      compare_writes("rnd");
    end

    // Reset mid-load with one pending byte
    start_dl(BIDX);
    strobe(0, 8'h5A);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero("midrst");
    idle(2);
    reset_n = 1'b1;
    act_q.delete();
    idle(5);
    @(negedge clk); ioctl_addr = 25'd1; ioctl_dout = 8'h77; ioctl_wr = 1'b1;
    @(negedge clk); ioctl_wr = 1'b0;
    idle(15);
    chk("midrst_nwr", 32'(act_q.size()), 32'd0);
    chk("midrst_hold", 32'(cpu_hold), 32'd0);
    ioctl_download = 1'b0;
    idle(3);
    start_dl(BIDX);
    chk("midrst_restart_hold", 32'(cpu_hold), 32'd1);
    strobe(4, 8'hC3); strobe(5, 8'h3C);
    end_dl();
    compare_writes("midrst_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
